event_led_stretcher: RTL and testbench

Converts single-cycle event pulses, such as a synchronized button-press strobe, into human-visible LED flashes. It sits on the output side of the board-I/O path. Each accepted event produces one LED-on period of fixed length followed by a mandatory dark gap, so back-to-back events remain distinguishable. Events that arrive while a flash is in progress are queued in a saturating pending counter and replayed in order.

---
 rtl/event_led_stretcher.sv | 206 ++++++++++++++++++++
 tb/tb_event_led_stretcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/event_led_stretcher.sv
//
// event_led_stretcher
// -------------------
// Turns single-cycle event strobes (for example a synchronised button-press
// pulse) into human-visible LED flashes. Every accepted event produces one
// LED-on period of ON_CYCLES clocks followed by a dark gap of OFF_CYCLES
// clocks, so two events in a row are still seen as two separate blinks.
//
// Build option:
//    EVENT_LED_STRETCHER_QUEUE_EN
//       defined     : events arriving during a flash or gap are counted in a
//                     saturating pending counter and replayed in order.
//       not defined : no pending counter exists, pending_o reads 0, and any
//                     event arriving during a flash or gap is discarded
//                     (except on the final gap cycle, where it starts the
//                     next flash directly).
//
// Parameters:
//    ON_CYCLES   LED-on duration in clk100_i cycles (>= 1)
//    OFF_CYCLES  minimum dark gap after each flash, in cycles (>= 1)
//    PEND_W      pending counter width, queue capacity 2^PEND_W - 1
//
// Ports:
//    clk100_i    100 MHz system clock, rising-edge active
//    rst_i       asynchronous active-high reset
//    event_i     event strobe, one event per high cycle, already synchronous
//    led_o       LED drive, high during a flash (registered)
//    busy_o      high while a flash or its gap is in progress (registered)
//    pending_o   number of queued events not yet started (registered)
//    drop_o      sticky, set once any event has been lost (registered)
//
module event_led_stretcher #(
   parameter int ON_CYCLES  = 10_000_000,
   parameter int OFF_CYCLES = 5_000_000,
   parameter int PEND_W     = 4
) (
   input  logic              clk100_i,
   input  logic              rst_i,
   input  logic              event_i,
   output logic              led_o,
   output logic              busy_o,
   output logic [PEND_W-1:0] pending_o,
   output logic              drop_o
);

   // One down-counter is shared between the ON and GAP phases, so it is
   // sized for whichever of the two phases is longer.
   localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TMR_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
   localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [TMR_W-1:0]  r_tmr;
   logic [TMR_W-1:0]  w_tmrNext;

   logic              r_led;
   logic              r_busy;
   logic              r_drop;

   logic              w_tmrZero;
   logic              w_decide;
   logic              w_pendNonZero;
   logic              w_request;
   logic              w_start;
   logic              w_queueEvent;
   logic              w_dropEvent;

   // A "decision point" is any cycle where the FSM is free to start a new
   // flash: always in IDLE, and on the very last cycle of the dark gap. Doing
   // the decision on the last gap cycle is what lets queued flashes run
   // back-to-back with period ON_CYCLES + OFF_CYCLES and no IDLE cycle.
   assign w_tmrZero = (r_tmr == '0);
   assign w_decide  = (r_state == S_IDLE) || ((r_state == S_GAP) && w_tmrZero);
   assign w_request = event_i || w_pendNonZero;
   assign w_start   = w_decide && w_request;

   // An event that arrives outside a decision point cannot be served now; it
   // either goes into the queue or is lost.
   assign w_queueEvent = event_i && !w_decide;

   // Next-state and timer logic. The timer is reloaded on every phase entry
   // and counts down to zero; the zero cycle is the last cycle of the phase.
   always_comb begin
      w_nextState = r_state;
      w_tmrNext   = r_tmr;
      case (r_state)
         S_IDLE: begin
            if (w_request) begin
               w_nextState = S_ON;
               w_tmrNext   = ON_LOAD;
            end
         end
         S_ON: begin
            if (w_tmrZero) begin
               w_nextState = S_GAP;
               w_tmrNext   = OFF_LOAD;
            end else begin
               w_tmrNext   = r_tmr - TMR_ONE;
            end
         end
         S_GAP: begin
            if (w_tmrZero) begin
               if (w_request) begin
                  w_nextState = S_ON;
                  w_tmrNext   = ON_LOAD;
               end else begin
                  w_nextState = S_IDLE;
                  w_tmrNext   = '0;
               end
            end else begin
               w_tmrNext   = r_tmr - TMR_ONE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
            w_tmrNext   = '0;
         end
      endcase
   end

   // FSM state and shared timer. Reset drops any flash in progress at once.
   always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_nextState;
         r_tmr   <= w_tmrNext;
      end
   end

   // Output registers. busy_o is taken from the next state so it equals
   // "state is ON or GAP" exactly. led_o is retimed one cycle behind the FSM,
   // which gives the one-cycle event-to-LED latency while keeping the flash
   // length exactly ON_CYCLES and the dark gap exactly OFF_CYCLES.
   always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
         r_led  <= 1'b0;
         r_busy <= 1'b0;
         r_drop <= 1'b0;
      end else begin
         r_led  <= (r_state == S_ON);
         r_busy <= (w_nextState != S_IDLE);
         if (w_dropEvent) begin
            r_drop <= 1'b1;
         end
      end
   end

   assign led_o  = r_led;
   assign busy_o = r_busy;
   assign drop_o = r_drop;

`ifdef EVENT_LED_STRETCHER_QUEUE_EN

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [PEND_W-1:0] r_pending;
   logic              w_consumePend;
   logic              w_pendInc;

   // A started flash consumes the live event if there is one, otherwise it
   // consumes the oldest queued event. Because the live event is preferred,
   // a consume and a queue increment can never both hit the counter in the
   // same cycle: "event arrives while a queued one starts" simply leaves the
   // count unchanged with nothing lost.
   assign w_pendNonZero = (r_pending != '0);
   assign w_consumePend = w_start && !event_i;
   assign w_pendInc     = w_queueEvent && (r_pending != PEND_MAX);
   assign w_dropEvent   = w_queueEvent && (r_pending == PEND_MAX);

   // Saturating pending counter.
   always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
         r_pending <= '0;
      end else if (w_consumePend) begin
         r_pending <= r_pending - PEND_ONE;
      end else if (w_pendInc) begin
         r_pending <= r_pending + PEND_ONE;
      end
   end

   assign pending_o = r_pending;

`else

   // Without the queue only the live strobe can request a flash, and any
   // strobe that cannot be served immediately is lost.
   assign w_pendNonZero = 1'b0;
   assign w_dropEvent   = w_queueEvent;
   assign pending_o     = '0;

`endif

endmodule

// File: tb/tb_event_led_stretcher.sv
//
// Testbench for event_led_stretcher (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2).
// Directed scenarios plus a long randomised run, all compared cycle by cycle
// against a timeline model: each flash is remembered by the edge it started
// on, and everything else (LED window, busy window, next point where a flash
// may start) is plain arithmetic on that start edge.
//
module tb_event_led_stretcher;

   localparam int ON_CYCLES  = 4;
   localparam int OFF_CYCLES = 3;
   localparam int PEND_W     = 2;
   localparam int PEND_MAX   = (1 << PEND_W) - 1;

   logic              clk100_i;
   logic              rst_i;
   logic              event_i;
   logic              led_o;
   logic              busy_o;
   logic [PEND_W-1:0] pending_o;
   logic              drop_o;

   int assertCount;
   int failCount;

   // Model state: edge number since reset, edge of the latest flash start,
   // first edge at which a new flash may start, queue depth and drop flag.
   int mEdge;
   int mLastStart;
   int mNextDecision;
   int mPend;
   int mDrop;
   int mLed;
   int mBusy;
   int flashCount;

   event_led_stretcher #(
      .ON_CYCLES  (ON_CYCLES),
      .OFF_CYCLES (OFF_CYCLES),
      .PEND_W     (PEND_W)
   ) dut (
      .clk100_i  (clk100_i),
      .rst_i     (rst_i),
      .event_i   (event_i),
      .led_o     (led_o),
      .busy_o    (busy_o),
      .pending_o (pending_o),
      .drop_o    (drop_o)
   );

   // 100 MHz clock
   initial clk100_i = 1'b0;
   always #5 clk100_i = ~clk100_i;

   // Single comparison point: counts every comparison and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at model edge %0d: got %0d, expected %0d", tag, mEdge, observed, expected);
      end
   endtask

   // Model reset: nothing started, the next edge is free to start a flash.
   function automatic void modelReset();
      mEdge         = 0;
      mLastStart    = -100;
      mNextDecision = 0;
      mPend         = 0;
      mDrop         = 0;
      mLed          = 0;
      mBusy         = 0;
   endfunction

   // Advance the model by one clock edge that sampled event value ev.
   function automatic void modelStep(input bit ev);
      mEdge++;
      if (mEdge >= mNextDecision) begin
         if (ev || (mPend > 0)) begin
            if (!ev) mPend--;
            mLastStart    = mEdge;
            mNextDecision = mEdge + ON_CYCLES + OFF_CYCLES;
            flashCount++;
         end
      end else if (ev) begin
`ifdef EVENT_LED_STRETCHER_QUEUE_EN
         if (mPend == PEND_MAX) mDrop = 1;
         else mPend++;
`else
         mDrop = 1;
`endif
      end
      mBusy = (mEdge < mNextDecision) ? 1 : 0;
      mLed  = ((mEdge - mLastStart >= 1) && (mEdge - mLastStart <= ON_CYCLES)) ? 1 : 0;
   endfunction

   // Drive one cycle of event_i, let the DUT and model take the edge, then
   // compare all outputs shortly after the edge.
   task automatic applyStimulus(input bit ev);
      event_i = ev;
      @(posedge clk100_i);
      modelStep(ev);
      #1;
      checkOutput("led_o", int'(led_o), mLed);
      checkOutput("busy_o", int'(busy_o), mBusy);
      checkOutput("pending_o", int'(pending_o), mPend);
      checkOutput("drop_o", int'(drop_o), mDrop);
   endtask

   task automatic applyIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0);
   endtask

   // Synchronous-looking reset pulse, released away from the clock edge.
   task automatic applyReset();
      event_i = 1'b0;
      rst_i   = 1'b1;
      @(posedge clk100_i);
      #1;
      checkOutput("reset led_o", int'(led_o), 0);
      checkOutput("reset busy_o", int'(busy_o), 0);
      checkOutput("reset pending_o", int'(pending_o), 0);
      checkOutput("reset drop_o", int'(drop_o), 0);
      @(posedge clk100_i);
      #1;
      rst_i = 1'b0;
      modelReset();
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      flashCount  = 0;
      event_i     = 1'b0;
      rst_i       = 1'b1;
      modelReset();

      applyReset();

      // Single isolated event
      applyIdle(9);
      applyStimulus(1'b1);
      applyIdle(15);

      // Three events, two of them queued behind the first flash
      applyReset();
      applyIdle(9);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyIdle(25);

      // Queue saturation: a burst during the first flash, exactly four flashes
      applyReset();
      flashCount = 0;
      applyIdle(3);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1);
      applyIdle(40);
`ifdef EVENT_LED_STRETCHER_QUEUE_EN
      checkOutput("saturation flash count", flashCount, 4);
`else
      checkOutput("saturation flash count", flashCount, 1);
`endif

      // Event on the final gap cycle while one event is queued
      applyReset();
      applyIdle(2);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyIdle(4);
      applyStimulus(1'b1);
      applyIdle(20);

      // Asynchronous reset in the middle of a flash with a full queue
      applyReset();
      applyIdle(2);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("async reset led_o", int'(led_o), 0);
      checkOutput("async reset busy_o", int'(busy_o), 0);
      checkOutput("async reset pending_o", int'(pending_o), 0);
      checkOutput("async reset drop_o", int'(drop_o), 0);
      @(posedge clk100_i);
      #1;
      rst_i = 1'b0;
      modelReset();
      applyIdle(20);

      // Randomised traffic with varying event density
      for (int blk = 0; blk < 20; blk++) begin
         int density;
         density = int'($urandom_range(1, 8));
         for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 9) < density) ? 1'b1 : 1'b0);
         end
         if ($urandom_range(0, 4) == 0) applyReset();
      end
      applyIdle(60);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
